// File: rtl/shift_result_stage_pkg.sv
// Shared ALU definitions for the shift result stages.
// Width defaults and the N/Z/C/V flag bundle.
package shift_result_stage_pkg;

    localparam int DW_DEF    = 16;
    localparam int SW_DEF    = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic FLAG_V_ASR = 1'b0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/shift_result_stage_if.sv
// Handshake bundle between the shift mux, the result stage
// and the ALU writeback.
interface shift_result_stage_if
    import shift_result_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [SW-1:0] in_sh;
    logic [DW-1:0] in_r;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic          out_n;
    logic          out_z;
    logic          out_c;
    logic          out_v;

    modport slave (
        input  in_valid, in_a, in_sh, in_r, out_ready,
        output in_ready, out_valid, out_r,
        output out_n, out_z, out_c, out_v
    );

    modport master (
        output in_valid, in_a, in_sh, in_r, out_ready,
        input  in_ready, out_valid, out_r,
        input  out_n, out_z, out_c, out_v
    );
endinterface

// File: rtl/shift_result_stage_asr_carry_calc.sv
// Carry out of a right shift: the last bit shifted out,
// i.e. a[sh-1], and zero when nothing is shifted.
module asr_carry_calc
    import shift_result_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic [DW-1:0] a_i,
    input  logic [SW-1:0] sh_i,
    output logic          c_o
);
    logic [SW-1:0] idx;

    assign idx = sh_i - SW'(1);
    assign c_o = (sh_i != '0) && a_i[idx];
endmodule

// File: rtl/shift_result_stage.sv
// Registered ASR result stage: flags, 2-entry skid buffer
// and delivered-result counter toward ALU writeback.
module shift_result_stage
    import shift_result_stage_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int SW    = SW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_result_stage_if.slave io,
    output logic [CNT_W-1:0] res_count
);
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    out_r_q, out_r_d;
    logic [DW-1:0]    skid_r_q, skid_r_d;
    flags_t           out_f_q, out_f_d;
    flags_t           skid_f_q, skid_f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry;
    flags_t           in_f;
    logic             accept;
    logic             deliver;

    asr_carry_calc #(.DW(DW), .SW(SW)) u_carry (
        .a_i  (io.in_a),
        .sh_i (io.in_sh),
        .c_o  (carry)
    );

    assign in_f.n = io.in_r[DW-1];
    assign in_f.z = (io.in_r == '0);
    assign in_f.c = carry;
    assign in_f.v = FLAG_V_ASR;

    // state[1] is the skid-occupied bit, state[0] the output-valid bit
    assign io.in_ready  = ~state_q[1];
    assign io.out_valid = state_q[0];
    assign io.out_r     = out_r_q;
    assign io.out_n     = out_f_q.n;
    assign io.out_z     = out_f_q.z;
    assign io.out_c     = out_f_q.c;
    assign io.out_v     = out_f_q.v;
    assign res_count    = cnt_q;

    assign accept  = io.in_valid && io.in_ready;
    assign deliver = io.out_valid && io.out_ready;

    always_comb begin
        state_d  = state_q;
        out_r_d  = out_r_q;
        out_f_d  = out_f_q;
        skid_r_d = skid_r_q;
        skid_f_d = skid_f_q;
        cnt_d    = cnt_q + CNT_W'(deliver);
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    out_r_d = io.in_r;
                    out_f_d = in_f;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    out_r_d = io.in_r;
                    out_f_d = in_f;
                end else if (accept) begin
                    state_d  = ST_FULL;
                    skid_r_d = io.in_r;
                    skid_f_d = in_f;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    state_d = ST_ONE;
                    out_r_d = skid_r_q;
                    out_f_d = skid_f_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            out_r_q  <= '0;
            out_f_q  <= '0;
            skid_r_q <= '0;
            skid_f_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_r_q  <= out_r_d;
            out_f_q  <= out_f_d;
            skid_r_q <= skid_r_d;
            skid_f_q <= skid_f_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_shift_result_stage.sv
// Bench for shift_result_stage: directed steps plus random
// traffic against a 2-deep FIFO reference model.
module tb_shift_result_stage;
    import shift_result_stage_pkg::*;

    typedef struct {
        logic [15:0] r;
        logic        n;
        logic        z;
        logic        c;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] res_count;

    shift_result_stage_if bus ();

    shift_result_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (bus),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    ent_t        q[$];
    int unsigned mcnt = 0;
    int          errors = 0;
    int          checks = 0;
    bit          last_acc = 1'b0;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] asr(logic [15:0] a, int sh);
        int v;
        v = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        for (int i = 0; i < sh; i++)
            v = (v < 0) ? -((-v + 1) / 2) : v / 2;
        return 16'(v);
    endfunction

    function automatic ent_t mk(logic [15:0] a, int sh, logic [15:0] r);
        ent_t e;
        int   p;
        e.r = r;
        e.n = (r >= 16'h8000);
        e.z = (r == 16'h0000);
        p = 1;
        for (int i = 1; i < sh; i++) p = p * 2;
        e.c = (sh == 0) ? 1'b0 : 1'(((int'(a) / p) % 2) != 0);
        return e;
    endfunction

    task automatic tick();
        bit   acc;
        bit   del;
        ent_t cur;
        acc = bus.in_valid && (q.size() < 2);
        del = (q.size() > 0) && bus.out_ready;
        cur = mk(bus.in_a, int'(bus.in_sh), bus.in_r);
        @(posedge clk);
        #1;
        if (del) begin
            q.delete(0);
            mcnt = (mcnt + 1) % 256;
        end
        if (acc) q.push_back(cur);
        last_acc = acc;
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("res_count", 32'(res_count), 32'(mcnt));
        if (q.size() > 0) begin
            chk("out_r", 32'(bus.out_r), 32'(q[0].r));
            chk("out_n", 32'(bus.out_n), 32'(q[0].n));
            chk("out_z", 32'(bus.out_z), 32'(q[0].z));
            chk("out_c", 32'(bus.out_c), 32'(q[0].c));
            chk("out_v", 32'(bus.out_v), 32'(0));
        end
    endtask

    task automatic drive(logic [15:0] a, logic [3:0] sh, logic [15:0] r);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_sh    = sh;
        bus.in_r     = r;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_a     = 'x;
        bus.in_sh    = 'x;
        bus.in_r     = 'x;
    endtask

    task automatic send(logic [15:0] a, logic [3:0] sh, logic [15:0] r);
        drive(a, sh, r);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("send_accept", 32'(last_acc), 32'(1));
        idle();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] seen[$];
    logic [15:0] ra;
    logic [3:0]  rs;
    int unsigned base;

    initial begin
        idle();
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_r", 32'(bus.out_r), 32'(0));
        chk("rst_flags", 32'({bus.out_n, bus.out_z, bus.out_c, bus.out_v}), 32'(0));
        chk("rst_count", 32'(res_count), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));

        // Basic ASR
        bus.out_ready = 1'b1;
        send(16'h8000, 4'd1, 16'hC000);
        chk("basic_r", 32'(bus.out_r), 32'h0000_C000);
        chk("basic_nzcv", 32'({bus.out_n, bus.out_z, bus.out_c, bus.out_v}), 32'(4'b1000));
        tick();
        chk("basic_count", 32'(res_count), 32'(1));

        // Carry and zero, then zero shift
        send(16'h0001, 4'd1, 16'h0000);
        chk("cz_r", 32'(bus.out_r), 32'(0));
        chk("cz_nzc", 32'({bus.out_n, bus.out_z, bus.out_c}), 32'(3'b011));
        send(16'h7FFF, 4'd0, 16'h7FFF);
        chk("sh0_nzc", 32'({bus.out_n, bus.out_z, bus.out_c}), 32'(3'b000));

        // Max shift
        send(16'hB0F0, 4'd15, 16'hFFFF);
        chk("max_b0f0_nc", 32'({bus.out_n, bus.out_c}), 32'(2'b10));
        send(16'hC000, 4'd15, 16'hFFFF);
        chk("max_c000_nc", 32'({bus.out_n, bus.out_c}), 32'(2'b11));
        tick();

        // Backpressure
        base = mcnt;
        bus.out_ready = 1'b0;
        send(16'h0001, 4'd0, 16'h0001);
        send(16'h0002, 4'd0, 16'h0002);
        chk("bp_full_ready", 32'(bus.in_ready), 32'(0));
        drive(16'h0003, 4'd0, 16'h0003);
        tick();
        tick();
        chk("bp_held_ready", 32'(bus.in_ready), 32'(0));
        chk("bp_held_r", 32'(bus.out_r), 32'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid && bus.out_ready) seen.push_back(bus.out_r);
            tick();
            if (last_acc) idle();
            if (q.size() == 0 && !bus.in_valid) break;
        end
        chk("bp_seen_n", 32'(seen.size()), 32'(3));
        for (int i = 0; i < seen.size(); i++)
            chk("bp_order", 32'(seen[i]), 32'(i + 1));
        chk("bp_count", 32'(res_count), 32'((base + 3) % 256));

        // Counter wrap
        async_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ra = 16'($urandom);
            rs = 4'($urandom_range(0, 15));
            send(ra, rs, asr(ra, int'(rs)));
        end
        chk("wrap_255", 32'(res_count), 32'(255));
        tick();
        chk("wrap_0", 32'(res_count), 32'(0));

        // Reset while full
        bus.out_ready = 1'b0;
        send(16'h1234, 4'd2, asr(16'h1234, 2));
        send(16'h8765, 4'd3, asr(16'h8765, 3));
        chk("pre_rst_ready", 32'(bus.in_ready), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_r", 32'(bus.out_r), 32'(0));
        chk("mid_rst_count", 32'(res_count), 32'(0));
        q.delete();
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.in_ready), 32'(1));
        repeat (3) tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (!bus.in_valid || last_acc) begin
                if ($urandom_range(0, 1) == 1) begin
                    ra = 16'($urandom);
                    rs = 4'($urandom_range(0, 15));
                    drive(ra, rs, asr(ra, int'(rs)));
                end else begin
                    idle();
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_result_stage.md
Name: shift_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit arithmetic-shift-right mux in the ALU.
- Captures the mux result together with the operand and shift amount that produced it.
- Computes the N/Z/C/V flags and presents result plus flags on a valid/ready interface toward the ALU writeback.
- Holds a 2-entry skid buffer so the writeback can stall without stalling the mux in the same cycle.

Parameters:
- DW, 16, data width of operand and result.
- SW, 4, shift-amount width; must equal log2(DW).
- CNT_W, 8, width of the delivered-result counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a result this cycle.
- in_ready  output  1  stage can accept this cycle.
- in_a  input  DW  unshifted operand fed to the mux.
- in_sh  input  SW  shift amount (the mux OP input).
- in_r  input  DW  mux output R for in_a/in_sh.
- out_valid  output  1  out_r/flags hold a valid result.
- out_ready  input  1  downstream consumes when high with out_valid.
- out_r  output  DW  registered result.
- out_n  output  1  negative flag, equal to out_r[DW-1].
- out_z  output  1  zero flag, set when out_r == 0.
- out_c  output  1  carry flag, last bit shifted out.
- out_v  output  1  overflow flag, always 0 for arithmetic shift right.
- res_count  output  CNT_W  count of results delivered downstream.

Behaviour:
- Reset (async assert, sync-released by clk):
  - out_valid=0, out_r=0, out_n=out_z=out_c=out_v=0, res_count=0.
  - Skid buffer empty, so in_ready=1 once rst_n is high.
- Flag computation on the input side, one set per accepted beat:
  - N=in_r[DW-1].
  - Z=(in_r==0).
  - C=0 if in_sh==0, else in_a[in_sh-1]. For in_sh=15 this is in_a[14].
  - V=0.
- Result, N, Z and C are stored as one entry; the entry never splits.
- in_ready is driven only from the skid-occupied register: in_ready = !skid_valid. It has no combinational path from out_ready.
- Accept happens on in_valid && in_ready. Deliver happens on out_valid && out_ready.
- States (derived from the out_valid and skid_valid registers):
  - EMPTY: out_valid=0, skid empty.
    - Accept -> ONE; the entry is loaded into the output register.
  - ONE: out_valid=1, skid empty.
    - Accept and deliver -> ONE; output register takes the new entry.
    - Accept, no deliver -> FULL; the entry goes to skid.
    - Deliver, no accept -> EMPTY.
    - Neither -> hold.
  - FULL: out_valid=1, skid valid, in_ready=0.
    - Deliver -> ONE; skid moves to the output register, skid clears.
    - No deliver -> hold.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Ordering is strictly FIFO; there is no bypass of an older entry.
- Outputs are stable while out_valid=1 and out_ready=0; the downstream may sample at any time.
- in_valid while in_ready=0 is ignored; the upstream must hold its data.
- res_count increments by 1 on each deliver and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: both entries are discarded immediately and the counter clears. No partial deliver occurs.
- X on inputs while in_valid=0 must not propagate into the registers.

Decomposition:
- Shared ALU package holds:
  - DW and SW defaults.
  - A flag struct/bundle {n,z,c,v}.
  - Constant FLAG_V_ASR=0.
- One sub-module, asr_carry_calc: combinational C from in_a/in_sh. It is reusable by the logical-shift-right stage.
- The skid buffer stays inline.

Test Plan:
- Basic ASR: in_a=16'h8000, in_sh=1, in_r=16'hC000, out_ready=1 -> next cycle out_r=C000, N=1, Z=0, C=0, V=0, res_count=1.
- Carry and zero: in_a=16'h0001, in_sh=1, in_r=16'h0000 -> out_r=0, Z=1, C=1, N=0. Also in_sh=0, in_a=in_r=16'h7FFF -> C=0, N=0, Z=0.
- Max shift: in_a=16'hB0F0, in_sh=15, in_r=16'hFFFF -> N=1, C=in_a[14]=0. Repeat with in_a=16'hC000 -> C=1.
- Backpressure: out_ready=0, push results 0x0001, 0x0002, 0x0003 back to back -> first two accepted, in_ready=0 on the cycle after the second accept, third held by upstream. Raise out_ready -> outputs 1, 2, 3 in order, res_count=3, no beat dropped or duplicated.
- Counter wrap: deliver 256 results with out_ready=1 -> res_count returns to 0 after the 256th.
- Reset mid-operation: stage FULL, assert rst_n=0 asynchronously mid-cycle -> out_valid=0, out_r=0, res_count=0 immediately. in_ready=1 on the first cycle after release, and no stale entry ever appears.
